// File: rtl/heartbeat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_pkg
// Purpose  : Shared definitions for the multi-channel heartbeat parser:
//            parser state encoding, default SYNC word, frame length and a
//            decoded-frame record for the default 8-bit configuration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package heartbeat_pkg;

    // Parser states, one per frame field position.
    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_CH   = 3'd1,
        ST_SEQ  = 3'd2,
        ST_STAT = 3'd3,
        ST_CHK  = 3'd4
    } hb_state_e;

    // Default frame start word (zero-extended by the parser to DATA_W).
    localparam logic [7:0] HB_SYNC_DEFAULT = 8'hA5;

    // Words per frame: SYNC, CH, SEQ, STAT, CHK.
    localparam int HB_FRAME_LEN = 5;

    // Decoded frame for the default DATA_W=8 configuration.
    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] seq;
        logic [7:0] status;
    } hb_frame_t;

endpackage : heartbeat_pkg
`default_nettype wire

// File: rtl/heartbeat_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_watchdog
// Purpose  : Liveness timer for one heartbeat source. A kick sets alive and
//            restarts the count; alive stays high for exactly TIMEOUT_CYCLES
//            cycles after the last kick, then drops.
// Ports    : clk   - clock
//            rst   - asynchronous active-high reset
//            kick  - good frame committed for this channel
//            alive - liveness flag
// Revision : 1.0 - initial release
// ============================================================================
module heartbeat_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic alive
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] LAST_CNT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             alive_q, alive_d;

    always_comb begin
        cnt_d   = cnt_q;
        alive_d = alive_q;
        if (kick) begin
            // A kick on the expiry edge takes priority over the timeout.
            alive_d = 1'b1;
            cnt_d   = '0;
        end else if (alive_q) begin
            if (cnt_q == LAST_CNT) begin
                alive_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alive_q <= alive_d;
        end
    end

    assign alive = alive_q;

endmodule : heartbeat_watchdog
`default_nettype wire

// File: rtl/parse_heartbeat_mc.sv
`default_nettype none
// ============================================================================
// Module   : parse_heartbeat_mc
// Purpose  : Multi-channel heartbeat frame parser with liveness watchdog.
//            Hunts SYNC-delimited frames (SYNC, CH, SEQ, STAT, CHK) on a
//            valid/ready word stream, validates channel range, XOR checksum
//            and per-channel sequence continuity, and presents decoded
//            frames on a valid/ready output.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            en                    - parser enable (0 aborts partial frames)
//            in_valid/in_data      - input word stream
//            in_ready              - input accept (low while output stalled)
//            out_valid/out_ready   - decoded frame handshake
//            out_ch/out_seq/out_status - decoded frame fields
//            alive                 - per-channel liveness
//            chk_err/ch_err/seq_err - one-cycle error pulses
//            err_count             - saturating error total
// Revision : 1.0 - initial release
// ============================================================================
module parse_heartbeat_mc
    import heartbeat_pkg::*;
#(
    parameter int                DATA_W         = 8,
    parameter int                NUM_CH         = 4,
    parameter logic [DATA_W-1:0] SYNC           = DATA_W'(HB_SYNC_DEFAULT),
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                CNT_W          = 16,
    localparam int               CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_seq,
    output logic [DATA_W-1:0] out_status,
    output logic [NUM_CH-1:0] alive,
    output logic              chk_err,
    output logic              ch_err,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] S_HUNT = 3'(ST_HUNT);
    localparam logic [2:0] S_CH   = 3'(ST_CH);
    localparam logic [2:0] S_SEQ  = 3'(ST_SEQ);
    localparam logic [2:0] S_STAT = 3'(ST_STAT);
    localparam logic [2:0] S_CHK  = 3'(ST_CHK);

    localparam logic [DATA_W:0]  CH_LIMIT = (DATA_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Decoded frame record sized to this instance.
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] seq;
        logic [DATA_W-1:0] status;
    } frame_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] seq_q, seq_d;
    logic [DATA_W-1:0] stat_q, stat_d;
    logic [DATA_W-1:0] xor_q, xor_d;

    frame_t            out_frame_q, out_frame_d;
    logic              out_valid_q, out_valid_d;

    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [DATA_W-1:0] last_seq_q [NUM_CH];
    logic [DATA_W-1:0] last_seq_d [NUM_CH];

    logic              chk_err_q, chk_err_d;
    logic              ch_err_q, ch_err_d;
    logic              seq_err_q, seq_err_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic              w_accept;
    logic              w_commit;
    logic              w_any_err;
    logic [DATA_W-1:0] w_seq_expect;
    logic [NUM_CH-1:0] w_kick;
    logic [NUM_CH-1:0] w_alive;

    // Input is back-pressured only while a decoded frame is stalled.
    assign in_ready = !(out_valid_q && !out_ready);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        seq_d     = seq_q;
        stat_d    = stat_q;
        xor_d     = xor_q;
        chk_err_d = 1'b0;
        ch_err_d  = 1'b0;
        w_commit  = 1'b0;

        if (!en) begin
            // Disabled: discard any partial frame silently.
            state_d = S_HUNT;
        end else if (w_accept) begin
            case (state_q)
                S_HUNT: begin
                    if (in_data == SYNC) begin
                        state_d = S_CH;
                    end
                end
                S_CH: begin
                    if ({1'b0, in_data} >= CH_LIMIT) begin
                        ch_err_d = 1'b1;
                        state_d  = S_HUNT;
                    end else begin
                        ch_d    = in_data[CH_W-1:0];
                        xor_d   = in_data;
                        state_d = S_SEQ;
                    end
                end
                S_SEQ: begin
                    seq_d   = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_STAT;
                end
                S_STAT: begin
                    stat_d  = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (in_data == xor_q) begin
                        w_commit = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = S_HUNT;
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Commit, sequence tracking and output handshake
    // ------------------------------------------------------------------
    assign w_seq_expect = last_seq_q[ch_q] + DATA_W'(1);

    always_comb begin
        out_valid_d = out_valid_q;
        out_frame_d = out_frame_q;
        seen_d      = seen_q;
        last_seq_d  = last_seq_q;
        seq_err_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A commit cannot coincide with a stalled output because in_ready
        // is low then, so overwriting the fields here is always safe.
        if (w_commit) begin
            out_valid_d        = 1'b1;
            out_frame_d.ch     = ch_q;
            out_frame_d.seq    = seq_q;
            out_frame_d.status = stat_q;
            if (seen_q[ch_q] && (seq_q != w_seq_expect)) begin
                seq_err_d = 1'b1;
            end
            seen_d[ch_q]     = 1'b1;
            last_seq_d[ch_q] = seq_q;
        end
    end

    // The three error sources are mutually exclusive in any one cycle.
    assign w_any_err = chk_err_d | ch_err_d | seq_err_d;

    always_comb begin
        err_count_d = err_count_q;
        if (w_any_err && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HUNT;
            ch_q        <= '0;
            seq_q       <= '0;
            stat_q      <= '0;
            xor_q       <= '0;
            out_frame_q <= '0;
            out_valid_q <= 1'b0;
            seen_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                last_seq_q[i] <= '0;
            end
            chk_err_q   <= 1'b0;
            ch_err_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            seq_q       <= seq_d;
            stat_q      <= stat_d;
            xor_q       <= xor_d;
            out_frame_q <= out_frame_d;
            out_valid_q <= out_valid_d;
            seen_q      <= seen_d;
            last_seq_q  <= last_seq_d;
            chk_err_q   <= chk_err_d;
            ch_err_q    <= ch_err_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel liveness watchdogs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_wd
        assign w_kick[i] = w_commit && (ch_q == CH_W'(i));

        heartbeat_watchdog #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_wd (
            .clk   (clk),
            .rst   (rst),
            .kick  (w_kick[i]),
            .alive (w_alive[i])
        );
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = out_valid_q;
    assign out_ch     = out_frame_q.ch;
    assign out_seq    = out_frame_q.seq;
    assign out_status = out_frame_q.status;
    assign alive      = w_alive;
    assign chk_err    = chk_err_q;
    assign ch_err     = ch_err_q;
    assign seq_err    = seq_err_q;
    assign err_count  = err_count_q;

endmodule : parse_heartbeat_mc
`default_nettype wire

// File: tb/tb_parse_heartbeat_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_parse_heartbeat_mc
// Purpose  : Self-checking bench for parse_heartbeat_mc. Directed scenarios
//            followed by randomized frame traffic, all compared cycle by
//            cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parse_heartbeat_mc;
    import heartbeat_pkg::*;

    localparam int NCH = 4;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_ch;
    logic [7:0] out_seq;
    logic [7:0] out_status;
    logic [3:0] alive;
    logic       chk_err;
    logic       ch_err;
    logic       seq_err;
    logic [15:0] err_count;

    parse_heartbeat_mc #(
        .DATA_W         (8),
        .NUM_CH         (NCH),
        .SYNC           (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_seq    (out_seq),
        .out_status (out_status),
        .alive      (alive),
        .chk_err    (chk_err),
        .ch_err     (ch_err),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_mode = 1'b0;

    // ---------------- reference model state ----------------
    logic [7:0] m_frm[$];      // words collected for the frame in progress
    bit         m_ov;
    int         m_ch, m_seq, m_stat;
    bit         m_seen [NCH];
    int         m_last [NCH];
    int         m_left [NCH];  // remaining alive cycles per channel
    bit         m_chk_e, m_ch_e, m_seq_e;
    int         m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_frm.delete();
        m_ov = 0; m_ch = 0; m_seq = 0; m_stat = 0;
        m_chk_e = 0; m_ch_e = 0; m_seq_e = 0; m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_seen[i] = 0; m_last[i] = 0; m_left[i] = 0;
        end
    endfunction

    // Advance the model by one clock edge given whether a word is taken.
    function automatic void model_edge(input bit acc);
        bit commit = 0;
        int c = 0, s = 0, st = 0;
        m_chk_e = 0; m_ch_e = 0; m_seq_e = 0;
        if (!en) begin
            m_frm.delete();
        end else if (acc) begin
            if (m_frm.size() == 0) begin
                if (in_data == 8'hA5) m_frm.push_back(in_data);
            end else begin
                m_frm.push_back(in_data);
                if (m_frm.size() == 2 && m_frm[1] >= NCH) begin
                    m_ch_e = 1;
                    m_frm.delete();
                end else if (m_frm.size() == HB_FRAME_LEN) begin
                    if ((m_frm[1] ^ m_frm[2] ^ m_frm[3]) == m_frm[4]) begin
                        commit = 1;
                        c = m_frm[1]; s = m_frm[2]; st = m_frm[3];
                    end else begin
                        m_chk_e = 1;
                    end
                    m_frm.delete();
                end
            end
        end
        if (m_ov && out_ready) m_ov = 0;
        if (commit) begin
            m_ov = 1; m_ch = c; m_seq = s; m_stat = st;
            if (m_seen[c] && s != ((m_last[c] + 1) % 256)) m_seq_e = 1;
            m_last[c] = s;
            m_seen[c] = 1;
        end
        if ((m_chk_e || m_ch_e || m_seq_e) && m_cnt < 65535) m_cnt++;
        for (int i = 0; i < NCH; i++) begin
            if (commit && c == i) m_left[i] = TO;
            else if (m_left[i] > 0) m_left[i]--;
        end
    endfunction

    task automatic compare_all();
        logic [3:0] ae;
        for (int i = 0; i < NCH; i++) ae[i] = (m_left[i] > 0);
        check_eq("out_valid",  out_valid,  m_ov);
        check_eq("out_ch",     out_ch,     m_ch);
        check_eq("out_seq",    out_seq,    m_seq);
        check_eq("out_status", out_status, m_stat);
        check_eq("alive",      alive,      ae);
        check_eq("chk_err",    chk_err,    m_chk_e);
        check_eq("ch_err",     ch_err,     m_ch_e);
        check_eq("seq_err",    seq_err,    m_seq_e);
        check_eq("err_count",  err_count,  m_cnt);
    endtask

    // One clock: caller has set en/in_valid/in_data; called at edge+1.
    task automatic step(output bit acc);
        bit exp_rdy;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_rdy = !(m_ov && !out_ready);
        check_eq("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        model_edge(acc);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 8'($urandom);
            step(acc);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        bit acc = 0;
        int guard = 0;
        if (rand_mode) begin
            while ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && guard < 200) begin
            step(acc);
            guard++;
        end
        check_eq("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] s,
                              input logic [7:0] st, input bit bad);
        send_word(8'hA5);
        send_word(c);
        send_word(s);
        send_word(st);
        send_word(c ^ s ^ st ^ (bad ? 8'h5A : 8'h00));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit acc;
        rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        model_reset();
        #3;
        do_reset();

        // 1: basic frame with leading junk
        send_word(8'h00); send_word(8'h37);
        send_frame(8'h02, 8'h10, 8'h01, 0);
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_ch", out_ch, 2);
        check_eq("t1_seq", out_seq, 8'h10);
        check_eq("t1_stat", out_status, 8'h01);
        check_eq("t1_alive", alive, 4'b0100);
        check_eq("t1_errs", {chk_err, ch_err, seq_err}, 0);
        idle(2);

        // 2: checksum error, then channel error
        send_frame(8'h01, 8'h05, 8'h00, 1);
        check_eq("t2_chk", chk_err, 1);
        check_eq("t2_noval", out_valid, 0);
        check_eq("t2_cnt1", err_count, 1);
        send_word(8'hA5); send_word(8'h07);
        check_eq("t2_ch", ch_err, 1);
        check_eq("t2_cnt2", err_count, 2);
        idle(2);

        // 3: sequence continuity and wrap on channel 2
        send_frame(8'h02, 8'h10, 8'h01, 0);
        send_frame(8'h02, 8'h12, 8'h01, 0);
        check_eq("t3_seqerr", seq_err, 1);
        check_eq("t3_seq", out_seq, 8'h12);
        send_frame(8'h02, 8'hFF, 8'h01, 0);
        send_frame(8'h02, 8'h00, 8'h01, 0);
        check_eq("t3_wrap", seq_err, 0);
        check_eq("t3_wrapval", out_valid, 1);

        // 4: watchdog length and expiry-edge kick
        idle(TO + 20);
        send_frame(8'h02, 8'h01, 8'h00, 0);
        cnt = 0;
        while (alive[2] && cnt < 300) begin
            idle(1);
            cnt++;
        end
        check_eq("t4_alive_len", cnt, TO);
        send_frame(8'h02, 8'h02, 8'h00, 0);
        idle(TO - 5);
        send_frame(8'h02, 8'h03, 8'h00, 0);
        check_eq("t4_kick_wins", alive[2], 1);
        idle(1);
        check_eq("t4_still_alive", alive[2], 1);

        // 5: output back-pressure
        send_frame(8'h01, 8'h40, 8'h77, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA5;
        repeat (20) begin
            step(acc);
            check_eq("t5_stall_ready", in_ready, 0);
            check_eq("t5_stall_ch", out_ch, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check_eq("t5_drained", out_valid, 0);
        send_frame(8'h03, 8'h09, 8'h11, 0);
        check_eq("t5_next_ch", out_ch, 3);

        // 6: enable drop and reset mid-frame
        idle(2);
        send_word(8'hA5); send_word(8'h01); send_word(8'h05);
        en = 1'b0; idle(1); en = 1'b1;
        send_frame(8'h00, 8'h21, 8'h33, 0);
        check_eq("t6_en_ch", out_ch, 0);
        check_eq("t6_en_val", out_valid, 1);
        send_word(8'hA5); send_word(8'h01);
        do_reset();
        check_eq("t6_rst_cnt", err_count, 0);
        check_eq("t6_rst_alive", alive, 0);
        send_frame(8'h01, 8'h22, 8'h44, 0);
        check_eq("t6_post_rst", out_valid, 1);

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (300) begin
            int r;
            logic [7:0] c, s;
            r = $urandom_range(0, 9);
            c = 8'($urandom_range(0, NCH - 1));
            s = ($urandom_range(0, 1) != 0) ? 8'(m_last[c] + 1) : 8'($urandom);
            case (r)
                0, 1, 2, 3, 4: send_frame(c, s, 8'($urandom), 0);
                5: send_frame(c, s, 8'($urandom), 1);
                6: begin
                    send_word(8'hA5);
                    send_word(8'($urandom_range(NCH, 255)));
                end
                7: repeat ($urandom_range(1, 4)) send_word(8'($urandom));
                8: begin
                    send_word(8'hA5); send_word(c);
                    en = 1'b0; idle(1); en = 1'b1;
                end
                default: idle($urandom_range(0, 120));
            endcase
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_parse_heartbeat_mc
`default_nettype wire
